nios2_c_ledg_sequencer: RTL and testbench
=========================================

# nios2_c_ledg_sequencer

Autonomous LED pattern sequencer. It sits between the Nios II data master and the 8-bit green-LED PIO. Software loads up to DEPTH patterns, a dwell time and a mode over an Avalon-MM slave port. The block then replays the patterns by issuing single-beat Avalon-MM writes to the PIO data register at offset 0, so the CPU needs no involvement. It raises an interrupt when a one-shot sequence completes.

## Interface
Parameters:
- DEPTH, 8: number of pattern slots; power of 2, 2..8.
- LED_W, 8: pattern width; matches the PIO out_port width.
- DWELL_W, 24: width of the dwell counter in clk cycles.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_address  in  4  config slave word address.
- s_chipselect  in  1  slave select.
- s_write_n  in  1  active-low write strobe.
- s_writedata  in  32  slave write data.
- s_readdata  out  32  slave read data; combinational, zero wait states.
- m_address  out  2  master word address to the PIO; constant 0.
- m_chipselect  out  1  master request.
- m_write_n  out  1  active-low master write.
- m_writedata  out  32  {zero-extend, pattern[LED_W-1:0]}.
- m_waitrequest  in  1  interconnect stall.
- irq  out  1  level interrupt: done & irq_en.

## Operation
Register map (word address):
- 0 CTRL: bit0 run, bit1 loop, bit2 irq_en.
- 1 STATUS: bit0 busy, bit1 done (write 1 to clear), bits[6:4] current index.
- 2 DWELL: DWELL_W bits.
- 3 LENGTH: bits[3:0], number of patterns. Values above DEPTH are clamped to DEPTH.
- 8..8+DEPTH-1 PATTERN[i]: LED_W bits.
- Unmapped addresses read 0, and writes to them are ignored.

State machine IDLE, WRITE, DWELL:
- IDLE: a CTRL write with run=1 clears done, sets index=0 and enters WRITE.
  - If LENGTH=0, the block sets done immediately and stays IDLE, with no master write.
- WRITE: drives m_chipselect=1, m_write_n=0, m_writedata=PATTERN[index]. All three are held until an edge with m_waitrequest=0 (acceptance). The block then loads the dwell counter with max(DWELL,1) and goes to DWELL.
- DWELL: the counter decrements once per cycle. On reaching 0:
  - If index<LENGTH-1: index++ and go to WRITE.
  - Else, if loop=1: index=0 and go to WRITE.
  - Else: set done, clear the run bit, go to IDLE.
- Abort: a CTRL write with run=0 while busy.
  - In DWELL, the block goes to IDLE on the next edge.
  - In WRITE, the in-flight write finishes at acceptance and the block then goes to IDLE. A started Avalon write is never dropped.
  - done is not set on abort.
- busy = (state != IDLE).
- PATTERN, DWELL and LENGTH writes are allowed while busy.
  - A new pattern takes effect at the next WRITE entry that reads that slot.
  - A new DWELL value takes effect at the next counter load.
- A CTRL run=1 write while busy updates loop and irq_en only; it does not restart the sequence.

## Timing
- Reset values:
  - All registers 0 and state IDLE.
  - m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
  - irq=0, s_readdata=0.
- Start latency: for a CTRL write at edge N, m_chipselect is high in the cycle after edge N.
- Cadence: with no stalls, accepted master writes are spaced max(DWELL,1)+1 cycles apart. Each waitrequest cycle adds one cycle.
- DWELL=0 behaves the same as DWELL=1.
- irq rises in the cycle after the final dwell expires, provided irq_en=1. It stays high until done is cleared or irq_en is cleared.
- If a done W1C and a done set occur in the same cycle, the set wins.
- Reset asserted mid-write drops m_chipselect asynchronously.

## Structure
- Package nios2_c_ledg_seq_pkg holds:
  - the state enum;
  - register address constants (ADDR_CTRL, ADDR_STATUS, ADDR_DWELL, ADDR_LENGTH, ADDR_PAT_BASE);
  - the CTRL and STATUS bit positions.
- One sub-module, nios2_c_ledg_seq_dwell_timer: a loadable DWELL_W-bit down-counter with load, enable and expired signals.
- The pattern store is a flop array of DEPTH×LED_W, not RAM.

## Test plan
- Reset, then read every register: all return 0, irq=0, m_chipselect=0, m_write_n=1.
- Load patterns 0x01, 0x02, 0x04, DWELL=3, LENGTH=3, CTRL=0x5 (run, irq_en): master writes 0x01, 0x02, 0x04 accepted 4 cycles apart. After the last dwell, STATUS=0x2 and irq=1. Writing STATUS=0x2 drops irq.
- Loop mode: LENGTH=2, loop=1, patterns 0xAA and 0x55, DWELL=0: the writes alternate 0xAA, 0x55, 0xAA… every 2 cycles and done never sets.
- Stall: hold m_waitrequest for 5 cycles on the second write: writedata stays stable and the next write is delayed by exactly 5 cycles.
- Abort: write CTRL=0 during a stalled WRITE: the block completes that write, returns to IDLE with no further writes and done=0. Abort during DWELL: the block is IDLE on the next cycle.
- Edge cases:
  - LENGTH=0 with run: done is set immediately and no master write is issued.
  - LENGTH=15 is clamped to DEPTH=8, so exactly 8 writes occur.

Source files
------------

// File: rtl/nios2_c_ledg_seq_pkg.sv
// Shared types and register map for the green-LED pattern sequencer.
package nios2_c_ledg_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDwell
    } seq_state_e;

    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_STATUS   = 4'd1;
    localparam logic [3:0] ADDR_DWELL    = 4'd2;
    localparam logic [3:0] ADDR_LENGTH   = 4'd3;
    localparam logic [3:0] ADDR_PAT_BASE = 4'd8;

    localparam int unsigned CTRL_RUN     = 0;
    localparam int unsigned CTRL_LOOP    = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_IDX_LSB = 4;

endpackage

// File: rtl/nios2_c_ledg_seq_dwell_timer.sv
// Loadable down-counter timing the gap between successive LED writes.
module nios2_c_ledg_seq_dwell_timer #(
    parameter int unsigned DWELL_W = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_value_i,
    input  logic               enable_i,
    output logic               expired_o
);

    logic [DWELL_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (enable_i && (count_q != '0)) begin
            count_d = count_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // High during the last dwell cycle: the enabled edge that follows brings the count to 0.
    assign expired_o = (count_q == DWELL_W'(1));

endmodule

// File: rtl/nios2_c_ledg_sequencer.sv
// Replays software-loaded LED patterns to the PIO data register via an Avalon-MM master.
module nios2_c_ledg_sequencer
    import nios2_c_ledg_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned LED_W   = 8,
    parameter int unsigned DWELL_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        irq
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    seq_state_e         state_q, state_d;
    logic               run_q, run_d, loop_q, loop_d, irq_en_q, irq_en_d, done_q, done_d;
    logic [2:0]         index_q, index_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [3:0]         length_q, length_d;
    logic [LED_W-1:0]   wdata_q, wdata_d;
    logic [LED_W-1:0]   pattern_q [DEPTH];
    logic [LED_W-1:0]   pattern_d [DEPTH];

    logic               s_wr, ctrl_wr, abort, pat_hit, timer_load, timer_en, timer_expired;
    logic [IDX_W-1:0]   pat_sel;
    logic [2:0]         idx_next;
    logic [3:0]         length_eff;
    logic [DWELL_W-1:0] dwell_load;
    logic [31:0]        ctrl_rd, status_rd;
    logic               unused_wdata;

    assign s_wr       = s_chipselect && !s_write_n;
    assign ctrl_wr    = s_wr && (s_address == ADDR_CTRL);
    assign pat_hit    = s_address[3] && ({1'b0, s_address[2:0]} < 4'(DEPTH));
    assign pat_sel    = s_address[IDX_W-1:0];
    assign length_eff = (length_q > 4'(DEPTH)) ? 4'(DEPTH) : length_q;
    assign idx_next   = index_q + 3'd1;
    assign dwell_load = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
    // run_q only drops while busy through an abort, so it also covers an earlier abort.
    assign abort      = !run_q || (ctrl_wr && !s_writedata[CTRL_RUN]);
    assign unused_wdata = ^s_writedata;

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        loop_d     = loop_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        index_d    = index_q;
        dwell_d    = dwell_q;
        length_d   = length_q;
        wdata_d    = wdata_q;
        pattern_d  = pattern_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;

        if (ctrl_wr) begin
            loop_d   = s_writedata[CTRL_LOOP];
            irq_en_d = s_writedata[CTRL_IRQ_EN];
            if (state_q == StIdle || !s_writedata[CTRL_RUN]) begin
                run_d = s_writedata[CTRL_RUN];
            end
        end
        if (s_wr && (s_address == ADDR_STATUS) && s_writedata[STAT_DONE]) done_d = 1'b0;
        if (s_wr && (s_address == ADDR_DWELL))  dwell_d  = s_writedata[DWELL_W-1:0];
        if (s_wr && (s_address == ADDR_LENGTH)) length_d = s_writedata[3:0];
        if (s_wr && pat_hit) pattern_d[pat_sel] = s_writedata[LED_W-1:0];

        // Done sets are placed after the W1C above so a same-cycle set wins.
        unique case (state_q)
            StIdle: begin
                if (ctrl_wr && s_writedata[CTRL_RUN]) begin
                    index_d = 3'd0;
                    if (length_eff == 4'd0) begin
                        done_d = 1'b1;
                        run_d  = 1'b0;
                    end else begin
                        done_d  = 1'b0;
                        wdata_d = pattern_q[0];
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (!m_waitrequest) begin
                    if (abort) begin
                        state_d = StIdle;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = StDwell;
                    end
                end
            end
            StDwell: begin
                timer_en = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (timer_expired) begin
                    if (({1'b0, index_q} + 4'd1) < length_eff) begin
                        index_d = idx_next;
                        wdata_d = pattern_q[idx_next[IDX_W-1:0]];
                        state_d = StWrite;
                    end else if (loop_q) begin
                        index_d = 3'd0;
                        wdata_d = pattern_q[0];
                        state_d = StWrite;
                    end else begin
                        done_d  = 1'b1;
                        run_d   = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            run_q     <= 1'b0;
            loop_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            index_q   <= '0;
            dwell_q   <= '0;
            length_q  <= '0;
            wdata_q   <= '0;
            pattern_q <= '{default: '0};
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            loop_q    <= loop_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            index_q   <= index_d;
            dwell_q   <= dwell_d;
            length_q  <= length_d;
            wdata_q   <= wdata_d;
            pattern_q <= pattern_d;
        end
    end

    nios2_c_ledg_seq_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (timer_load),
        .load_value_i (dwell_load),
        .enable_i     (timer_en),
        .expired_o    (timer_expired)
    );

    always_comb begin
        ctrl_rd                          = '0;
        ctrl_rd[CTRL_RUN]                = run_q;
        ctrl_rd[CTRL_LOOP]               = loop_q;
        ctrl_rd[CTRL_IRQ_EN]             = irq_en_q;
        status_rd                        = '0;
        status_rd[STAT_BUSY]             = (state_q != StIdle);
        status_rd[STAT_DONE]             = done_q;
        status_rd[STAT_IDX_LSB +: 3]     = index_q;
        s_readdata                       = '0;
        if (s_chipselect) begin
            if (pat_hit) begin
                s_readdata = 32'(pattern_q[pat_sel]);
            end else begin
                case (s_address)
                    ADDR_CTRL:   s_readdata = ctrl_rd;
                    ADDR_STATUS: s_readdata = status_rd;
                    ADDR_DWELL:  s_readdata = 32'(dwell_q);
                    ADDR_LENGTH: s_readdata = 32'(length_q);
                    default:     s_readdata = '0;
                endcase
            end
        end
    end

    assign m_address    = 2'd0;
    assign m_chipselect = (state_q == StWrite);
    assign m_write_n    = (state_q != StWrite);
    assign m_writedata  = (state_q == StWrite) ? 32'(wdata_q) : '0;
    assign irq          = done_q && irq_en_q;

endmodule

// File: tb/tb_nios2_c_ledg_sequencer.sv
// Directed bench for the LED sequencer with a per-cycle behavioural model of the master stream.
module tb_nios2_c_ledg_sequencer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  s_address = '0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    nios2_c_ledg_sequencer #(
        .DEPTH   (8),
        .LED_W   (8),
        .DWELL_W (24)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_address     (s_address),
        .s_chipselect  (s_chipselect),
        .s_write_n     (s_write_n),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .irq           (irq)
    );

    int checks = 0;
    int failures = 0;

    // Model state: register shadows plus the expected progress of the running sequence.
    logic [7:0]  mdl_pat [DEPTH];
    int          mdl_len = 0, mdl_dwell = 0, mdl_idx = 0, done_due = -1;
    bit          mdl_loop = 0, mdl_irq_en = 0, mdl_done = 0, mdl_active = 0, mdl_stop = 0;
    bit          mon_en = 0, prev_stall = 0;
    logic [31:0] prev_wd = '0;
    int          cycle = 0, acc_count = 0, last_acc = -1, stalls = 0, last_gap = 0;
    logic [31:0] acc_log [$];

    function automatic int len_eff();
        return (mdl_len > DEPTH) ? DEPTH : mdl_len;
    endfunction

    function automatic int base_gap();
        return ((mdl_dwell == 0) ? 1 : mdl_dwell) + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            cycle++;
            if (done_due == cycle) mdl_done = 1;
            check("irq", {31'b0, irq}, {31'b0, mdl_done && mdl_irq_en});
            check("m_address", {30'b0, m_address}, 32'd0);
            check("m_write_n", {31'b0, m_write_n}, {31'b0, !m_chipselect});
            if (prev_stall) begin
                check("stall_hold_cs", {31'b0, m_chipselect}, 32'd1);
                check("stall_hold_data", m_writedata, prev_wd);
            end
            if (m_chipselect) begin
                if (m_waitrequest) begin
                    stalls++;
                end else begin
                    acc_count++;
                    acc_log.push_back(m_writedata);
                    if (!mdl_active) begin
                        fail_now("unexpected_master_write");
                    end else begin
                        check("m_writedata", m_writedata, {24'b0, mdl_pat[mdl_idx]});
                        if (last_acc >= 0) check("write_gap", 32'(cycle - last_acc), 32'(base_gap() + stalls));
                        last_gap = cycle - last_acc;
                        if (mdl_stop) begin
                            mdl_active = 0;
                            mdl_stop = 0;
                        end else if (mdl_idx + 1 < len_eff()) begin
                            mdl_idx++;
                        end else if (mdl_loop) begin
                            mdl_idx = 0;
                        end else begin
                            mdl_active = 0;
                            done_due = cycle + base_gap();
                        end
                    end
                    last_acc = cycle;
                    stalls = 0;
                end
            end
            prev_stall = m_chipselect && m_waitrequest;
            prev_wd = m_writedata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sw(input logic [3:0] a, input logic [31:0] d);
        s_address = a;
        s_writedata = d;
        s_chipselect = 1'b1;
        s_write_n = 1'b0;
        tick();
        s_chipselect = 1'b0;
        s_write_n = 1'b1;
        if (a == 4'd2) mdl_dwell = int'(d[23:0]);
        if (a == 4'd3) mdl_len = int'(d[3:0]);
        if (a >= 4'd8) mdl_pat[a - 4'd8] = d[7:0];
        if (a == 4'd1 && d[1]) mdl_done = 0;
        if (a == 4'd0) begin
            mdl_loop = d[1];
            mdl_irq_en = d[2];
            if (d[0] && !mdl_active) begin
                mdl_done = 0;
                mdl_idx = 0;
                done_due = -1;
                last_acc = -1;
                stalls = 0;
                if (len_eff() == 0) begin
                    mdl_done = 1;
                end else begin
                    mdl_active = 1;
                    check("start_latency_cs", {31'b0, m_chipselect}, 32'd1);
                end
            end
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        s_address = a;
        s_chipselect = 1'b1;
        s_write_n = 1'b1;
        #1;
        d = s_readdata;
        s_chipselect = 1'b0;
        tick();
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (acc_count < n && k < budget) begin
            tick();
            k++;
        end
        if (acc_count < n) fail_now("timeout_waiting_for_master_write");
    endtask

    task automatic wait_req(input int budget);
        int k = 0;
        while (!m_chipselect && k < budget) begin
            tick();
            k++;
        end
        if (!m_chipselect) fail_now("timeout_waiting_for_master_request");
    endtask

    initial begin
        logic [31:0] d;
        int base;
        for (int i = 0; i < DEPTH; i++) mdl_pat[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en = 1;

        // Reset state and register readback
        check("reset_irq", {31'b0, irq}, 32'd0);
        check("reset_m_cs", {31'b0, m_chipselect}, 32'd0);
        check("reset_m_write_n", {31'b0, m_write_n}, 32'd1);
        check("reset_m_writedata", m_writedata, 32'd0);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d);
            check($sformatf("reset_read_%0d", a), d, 32'd0);
        end
        sw(4'd5, 32'hFFFF_FFFF);
        rd(4'd5, d);
        check("unmapped_read", d, 32'd0);

        // One-shot sequence with irq
        sw(4'd8, 32'h01);
        sw(4'd9, 32'h02);
        sw(4'd10, 32'h04);
        sw(4'd2, 32'd3);
        sw(4'd3, 32'd3);
        base = acc_count;
        sw(4'd0, 32'h5);
        wait_acc(base + 3, 100);
        check("oneshot_gap_lit", 32'(last_gap), 32'd4);
        repeat (6) tick();
        rd(4'd1, d);
        check("oneshot_status", d & 32'h3, 32'h2);
        check("oneshot_irq_lit", {31'b0, irq}, 32'd1);
        if (acc_log.size() >= base + 3) begin
            check("oneshot_w0", acc_log[base], 32'h01);
            check("oneshot_w1", acc_log[base + 1], 32'h02);
            check("oneshot_w2", acc_log[base + 2], 32'h04);
        end else begin
            fail_now("oneshot_write_count");
        end
        sw(4'd1, 32'h2);
        check("w1c_irq_lit", {31'b0, irq}, 32'd0);

        // Stall on the second write
        base = acc_count;
        sw(4'd0, 32'h5);
        wait_acc(base + 1, 50);
        m_waitrequest = 1'b1;
        wait_req(50);
        repeat (5) tick();
        m_waitrequest = 1'b0;
        wait_acc(base + 2, 50);
        check("stall_gap_lit", 32'(last_gap), 32'd9);
        wait_acc(base + 3, 50);
        check("post_stall_gap_lit", 32'(last_gap), 32'd4);
        repeat (6) tick();
        sw(4'd1, 32'h2);

        // Abort during a stalled write: that write completes, nothing follows
        base = acc_count;
        sw(4'd0, 32'h5);
        wait_acc(base + 1, 50);
        m_waitrequest = 1'b1;
        wait_req(50);
        tick();
        mdl_stop = 1;
        sw(4'd0, 32'h0);
        tick();
        m_waitrequest = 1'b0;
        repeat (20) tick();
        check("abort_write_count", 32'(acc_count - base), 32'd2);
        rd(4'd1, d);
        check("abort_write_status", d & 32'h3, 32'h0);

        // Loop mode with DWELL=0, then abort during dwell
        sw(4'd8, 32'hAA);
        sw(4'd9, 32'h55);
        sw(4'd2, 32'd0);
        sw(4'd3, 32'd2);
        base = acc_count;
        sw(4'd0, 32'h3);
        wait_acc(base + 6, 100);
        check("loop_gap_lit", 32'(last_gap), 32'd2);
        sw(4'd0, 32'h0);
        mdl_active = 0;
        rd(4'd1, d);
        check("abort_dwell_status", d & 32'h3, 32'h0);
        repeat (10) tick();
        check("loop_write_count", 32'(acc_count - base), 32'd6);
        if (acc_log.size() >= base + 3) begin
            check("loop_w0", acc_log[base], 32'hAA);
            check("loop_w1", acc_log[base + 1], 32'h55);
            check("loop_w2", acc_log[base + 2], 32'hAA);
        end else begin
            fail_now("loop_write_log");
        end

        // LENGTH=0: immediate done, no master write
        sw(4'd3, 32'd0);
        base = acc_count;
        sw(4'd0, 32'h5);
        rd(4'd1, d);
        check("len0_status", d & 32'h3, 32'h2);
        check("len0_irq_lit", {31'b0, irq}, 32'd1);
        repeat (10) tick();
        check("len0_write_count", 32'(acc_count - base), 32'd0);
        sw(4'd1, 32'h2);

        // LENGTH=15 clamps to DEPTH
        for (int i = 0; i < DEPTH; i++) sw(4'(8 + i), 32'h10 + 32'(i));
        sw(4'd2, 32'd1);
        sw(4'd3, 32'd15);
        base = acc_count;
        sw(4'd0, 32'h1);
        wait_acc(base + 8, 200);
        repeat (10) tick();
        check("clamp_write_count", 32'(acc_count - base), 32'd8);
        rd(4'd1, d);
        check("clamp_status", d & 32'h3, 32'h2);
        if (acc_log.size() >= base + 8) check("clamp_last", acc_log[base + 7], 32'h17);
        else fail_now("clamp_write_log");
        sw(4'd1, 32'h2);

        // Asynchronous reset during a stalled write
        sw(4'd0, 32'h1);
        m_waitrequest = 1'b1;
        wait_req(50);
        mon_en = 0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_cs", {31'b0, m_chipselect}, 32'd0);
        check("async_reset_write_n", {31'b0, m_write_n}, 32'd1);
        m_waitrequest = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
